frame_collide: RTL and testbench
================================

Name: frame_collide

Overview:
- Downstream of the pipe renderer and the bird renderer; consumes their per-pixel RGB streams.
- Composites the final VGA pixel with priority bird > pipe > sky.
- Detects bird/pipe and bird/floor collisions per frame, counts pipes passed, and runs the IDLE/PLAY/OVER game state machine.
- Drives game_active, which gates the renderers' update requests.

Parameters:
- SKY_RGB, 24'h70C5CE, background colour {r,g,b} where neither sprite is drawn.
- BIRD_X, 10'd120, screen column used for pipe-pass scoring.
- FLOOR_Y, 9'd470, any bird pixel on a row >= FLOOR_Y is a floor hit.
- SCORE_W, 8, score counter width; saturating.
- PIX_LAT, 1, cycles of lag between the x/y inputs and the renderer RGB inputs (range 1..3).

Ports:
- clk  in  1  system clock.
- resetGame  in  1  asynchronous, active-high reset.
- x  in  10  current VGA column, 0..639.
- y  in  9  current VGA row, 0..479.
- pipe_r, pipe_g, pipe_b  in  8 each  pipe renderer pixel, valid PIX_LAT cycles after its x/y.
- bird_r, bird_g, bird_b  in  8 each  bird renderer pixel, same alignment as the pipe pixel.
- start  in  1  button level; edge-detected internally.
- vga_r, vga_g, vga_b  out  8 each  composited pixel, registered.
- frame_end  out  1  one-cycle pulse when the aligned pixel is (639,479).
- game_active  out  1  high only in PLAY.
- game_over  out  1  high only in OVER.
- collision  out  1  pulse, coincident with the frame_end that causes PLAY->OVER.
- score  out  SCORE_W  pipes passed.

Behaviour:
- Alignment
  - x/y are delayed PIX_LAT cycles through a shift register to form xa/ya.
  - All pixel logic uses xa/ya together with the RGB inputs of that cycle.
- Sprite presence
  - bird_on = any bird channel nonzero.
  - pipe_on = pipe_g nonzero.
- Composite
  - vga = bird RGB if bird_on, else pipe RGB if pipe_on, else SKY_RGB.
  - Registered: 1 cycle after the aligned pixel; total PIX_LAT+1 cycles after x/y.
- Per-frame flags (cleared at frame_end; a set condition on the frame_end pixel itself counts toward the frame that is ending):
  - hit_f: set if bird_on & pipe_on, or bird_on & ya >= FLOOR_Y.
  - at_col: set if pipe_on & xa == BIRD_X.
  - at_col_prev: loaded from at_col at each frame_end.
- frame_end: registered pulse, same cycle as the vga output for pixel (639,479).
- start_rise = start & ~start_q.
- FSM, reset state IDLE:
  - IDLE: start_rise -> PLAY; clear score.
  - PLAY: at frame_end evaluate, in order:
    - hit_f -> OVER; collision pulses. No score increment in that frame, even if a pass was also detected.
    - else if at_col_prev & ~at_col -> score+1, saturating at all-ones.
  - OVER: start_rise -> IDLE. Score is held until the IDLE->PLAY transition clears it.
  - start_rise in PLAY is ignored.
- Reset values: vga_r/g/b=0, frame_end=0, game_active=0, game_over=0, collision=0, score=0, all flags=0, alignment pipeline=0.
- Reset mid-frame:
  - Immediate return to IDLE with all flags cleared.
  - The first frame_end after release still pulses; flags only reflect pixels seen after release.
- x/y jumping mid-frame (no (639,479) seen) simply means no frame_end; flags keep accumulating.

Optional Feature:
- Macro: COLLIDE_FLASH_EN.
- Defined: an internal 4-bit frame counter increments at each frame_end while in OVER and resets on entry to OVER. While in OVER with counter bit3=1, vga outputs are bitwise inverted.
- Undefined: no counter; vga output in OVER is the plain composite, identical to PLAY rendering.

Test Plan:
- Reset, then sweep one frame with bird and pipe inputs all 0 -> vga = 0x70,0xC5,0xCE everywhere; frame_end exactly one pulse, PIX_LAT+1 cycles after x=639,y=479 is applied; score=0; game_active=0.
- start 0->1, hold high 10 cycles -> game_active=1 after one cycle, exactly one transition; then a frame with bird pixel (255,255,0) at (200,100) and pipe_g=255 at (200,100) -> collision and game_over assert at frame_end; vga at that pixel = (255,255,0).
- PLAY, frame N has pipe_g=255 at xa=120, frame N+1 has none -> score 0->1 at end of frame N+1; a third frame with none -> score stays 1.
- PLAY, bird pixel at row 470 and no pipe -> OVER at frame_end; same stimulus on row 469 -> stays PLAY.
- Preload score 255 (SCORE_W=8) via repeated passes, then another pass -> score stays 255; pass and hit in the same frame -> OVER, score unchanged.
- Assert resetGame mid-frame during PLAY, release, start_rise -> PLAY with score=0. With COLLIDE_FLASH_EN defined: 8 frames in OVER -> normal output, next 8 frames -> inverted (sky = 0x8F,0x3A,0x31).

Source files
------------

// File: rtl/frame_collide_if.sv
// Pixel-side bundle between the renderers and frame_collide: aligned-input x/y + RGB, composited VGA out, game status.
// The slave modport is the compositor's view; master is the renderer/driver side.
interface frame_collide_if #(
    parameter int SCORE_W = 8
);
    logic [9:0]         x;
    logic [8:0]         y;
    logic [7:0]         pipe_r;
    logic [7:0]         pipe_g;
    logic [7:0]         pipe_b;
    logic [7:0]         bird_r;
    logic [7:0]         bird_g;
    logic [7:0]         bird_b;
    logic               start;
    logic [7:0]         vga_r;
    logic [7:0]         vga_g;
    logic [7:0]         vga_b;
    logic               frame_end;
    logic               game_active;
    logic               game_over;
    logic               collision;
    logic [SCORE_W-1:0] score;

    modport master (
        output x, y, pipe_r, pipe_g, pipe_b, bird_r, bird_g, bird_b, start,
        input  vga_r, vga_g, vga_b, frame_end, game_active, game_over, collision, score
    );

    modport slave (
        input  x, y, pipe_r, pipe_g, pipe_b, bird_r, bird_g, bird_b, start,
        output vga_r, vga_g, vga_b, frame_end, game_active, game_over, collision, score
    );
endinterface

// File: rtl/frame_collide.sv
// Composites bird > pipe > sky, tracks per-frame collision/pass flags and runs IDLE/PLAY/OVER; COLLIDE_FLASH_EN adds OVER flashing.
// Latency: vga/frame_end/status are registered, PIX_LAT+1 cycles after the x/y they belong to.
// Backpressure: none; a free-running pixel stream, one pixel per clock.
module frame_collide #(
    parameter logic [23:0] SKY_RGB = 24'h70C5CE,
    parameter logic [9:0]  BIRD_X  = 10'd120,
    parameter logic [8:0]  FLOOR_Y = 9'd470,
    parameter int          SCORE_W = 8,
    parameter int          PIX_LAT = 1
) (
    input  logic            clk,
    input  logic            resetGame,
    frame_collide_if.slave  io
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [9:0]         xs_q [PIX_LAT];
    logic [8:0]         ys_q [PIX_LAT];
    logic [9:0]         xa;
    logic [8:0]         ya;
    logic [23:0]        bird_rgb, pipe_rgb, comp_rgb;
    logic               bird_on, pipe_on, fe_pix;
    logic               hit_tot, at_tot, start_rise, invert;
    logic               start_q;
    logic [23:0]        vga_q, vga_d;
    logic               frame_end_q;
    logic               collision_q, collision_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               hit_f_q, hit_f_d;
    logic               at_col_q, at_col_d;
    logic               at_col_prev_q, at_col_prev_d;

    // Delay x/y so they line up with the renderers' RGB of the same pixel.
    always_ff @(posedge clk or posedge resetGame) begin
        if (resetGame) begin
            for (int i = 0; i < PIX_LAT; i++) begin
                xs_q[i] <= '0;
                ys_q[i] <= '0;
            end
        end else begin
            xs_q[0] <= io.x;
            ys_q[0] <= io.y;
            for (int i = 1; i < PIX_LAT; i++) begin
                xs_q[i] <= xs_q[i-1];
                ys_q[i] <= ys_q[i-1];
            end
        end
    end

    assign xa = xs_q[PIX_LAT-1];
    assign ya = ys_q[PIX_LAT-1];

    assign bird_rgb   = {io.bird_r, io.bird_g, io.bird_b};
    assign pipe_rgb   = {io.pipe_r, io.pipe_g, io.pipe_b};
    assign bird_on    = |bird_rgb;
    assign pipe_on    = |io.pipe_g;
    assign comp_rgb   = bird_on ? bird_rgb : (pipe_on ? pipe_rgb : SKY_RGB);
    assign fe_pix     = (xa == 10'd639) && (ya == 9'd479);
    assign start_rise = io.start & ~start_q;

    // The frame_end pixel itself still counts toward the frame it closes.
    assign hit_tot = hit_f_q  | (bird_on & (pipe_on | (ya >= FLOOR_Y)));
    assign at_tot  = at_col_q | (pipe_on & (xa == BIRD_X));

    always_comb begin
        hit_f_d       = fe_pix ? 1'b0 : hit_tot;
        at_col_d      = fe_pix ? 1'b0 : at_tot;
        at_col_prev_d = fe_pix ? at_tot : at_col_prev_q;
    end

    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        collision_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d = ST_PLAY;
                    score_d = '0;
                end
            end
            ST_PLAY: begin
                if (fe_pix) begin
                    if (hit_tot) begin
                        state_d     = ST_OVER;
                        collision_d = 1'b1;
                    end else if (at_col_prev_q && !at_tot && (score_q != '1)) begin
                        score_d = score_q + SCORE_W'(1);
                    end
                end
            end
            ST_OVER: begin
                if (start_rise) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef COLLIDE_FLASH_EN
    logic [3:0] flash_q, flash_d;

    always_comb begin
        flash_d = flash_q;
        if (state_q == ST_PLAY && state_d == ST_OVER) begin
            flash_d = 4'd0;
        end else if (state_q == ST_OVER && fe_pix) begin
            flash_d = flash_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge resetGame) begin
        if (resetGame) begin
            flash_q <= 4'd0;
        end else begin
            flash_q <= flash_d;
        end
    end

    assign invert = (state_q == ST_OVER) && flash_q[3];
`else
    assign invert = 1'b0;
`endif

    assign vga_d = invert ? ~comp_rgb : comp_rgb;

    always_ff @(posedge clk or posedge resetGame) begin
        if (resetGame) begin
            state_q       <= ST_IDLE;
            start_q       <= 1'b0;
            vga_q         <= '0;
            frame_end_q   <= 1'b0;
            collision_q   <= 1'b0;
            score_q       <= '0;
            hit_f_q       <= 1'b0;
            at_col_q      <= 1'b0;
            at_col_prev_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_q       <= io.start;
            vga_q         <= vga_d;
            frame_end_q   <= fe_pix;
            collision_q   <= collision_d;
            score_q       <= score_d;
            hit_f_q       <= hit_f_d;
            at_col_q      <= at_col_d;
            at_col_prev_q <= at_col_prev_d;
        end
    end

    assign io.vga_r       = vga_q[23:16];
    assign io.vga_g       = vga_q[15:8];
    assign io.vga_b       = vga_q[7:0];
    assign io.frame_end   = frame_end_q;
    assign io.game_active = (state_q == ST_PLAY);
    assign io.game_over   = (state_q == ST_OVER);
    assign io.collision   = collision_q;
    assign io.score       = score_q;

endmodule

// File: tb/tb_frame_collide.sv
// Randomized and directed pixel streams for frame_collide, checked every cycle against a frame-level reference model.
module tb_frame_collide;
    localparam int PIX_LAT = 1;
    localparam int SCORE_W = 8;
    localparam int SAT     = (1 << SCORE_W) - 1;
`ifdef COLLIDE_FLASH_EN
    localparam bit FLASH = 1'b1;
`else
    localparam bit FLASH = 1'b0;
`endif
    localparam logic [23:0] SKY = 24'h70C5CE;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic resetGame;

    frame_collide_if #(.SCORE_W(SCORE_W)) bus ();

    frame_collide #(
        .SKY_RGB(SKY), .BIRD_X(10'd120), .FLOOR_Y(9'd470),
        .SCORE_W(SCORE_W), .PIX_LAT(PIX_LAT)
    ) dut (
        .clk(clk), .resetGame(resetGame), .io(bus)
    );

    int total = 0;
    int bad = 0;
    int fe_cnt = 0;
    int coll_cnt = 0;
    bit cmp_en = 1'b0;
    logic start_lvl = 1'b0;

    // Expected DUT outputs after the next active edge.
    logic [23:0] e_vga;
    logic        e_fe, e_act, e_over, e_coll;
    int          e_score;

    // Reference model: game state 0=idle 1=play 2=over, plus per-frame facts.
    int m_state, m_score, m_cnt;
    bit m_hit, m_at, m_prev, m_sp;
    logic [9:0]  qx[$];
    logic [8:0]  qy[$];
    logic [23:0] qb[$];
    logic [23:0] qp[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("vga",         32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'(e_vga));
            chk("frame_end",   32'(bus.frame_end),   32'(e_fe));
            chk("game_active", 32'(bus.game_active), 32'(e_act));
            chk("game_over",   32'(bus.game_over),   32'(e_over));
            chk("collision",   32'(bus.collision),   32'(e_coll));
            chk("score",       32'(bus.score),       32'(e_score));
        end
    end

    always @(negedge clk) begin
        if (bus.frame_end) fe_cnt++;
        if (bus.collision) coll_cnt++;
    end

    function automatic logic [23:0] rnd24();
        logic [31:0] r;
        r = $urandom();
        return r[23:0];
    endfunction

    task automatic model_reset();
        m_state = 0; m_score = 0; m_cnt = 0;
        m_hit = 0; m_at = 0; m_prev = 0; m_sp = 0;
        qx.delete(); qy.delete(); qb.delete(); qp.delete();
        for (int i = 0; i < PIX_LAT; i++) begin
            qx.push_back(10'd0); qy.push_back(9'd0);
            qb.push_back(24'd0); qp.push_back(24'd0);
        end
    endtask

    // One aligned pixel: what the screen shows and how the game reacts to it.
    task automatic model(input logic [9:0] ax, input logic [8:0] ay,
                         input logic [23:0] ab, input logic [23:0] ap, input logic st);
        bit bon, pon, fe, hit, at, rise;
        int old;
        logic [23:0] c;
        bon  = (ab != 24'd0);
        pon  = (ap[15:8] != 8'd0);
        c    = bon ? ab : (pon ? ap : SKY);
        fe   = (ax == 10'd639) && (ay == 9'd479);
        hit  = m_hit || (bon && (pon || ay >= 9'd470));
        at   = m_at || (pon && ax == 10'd120);
        rise = st && !m_sp;
        old  = m_state;
        e_vga  = (FLASH && old == 2 && m_cnt >= 8) ? ~c : c;
        e_coll = 1'b0;
        if (old == 1 && fe) begin
            if (hit) begin
                m_state = 2; e_coll = 1'b1; m_cnt = 0;
            end else if (m_prev && !at && m_score < SAT) begin
                m_score = m_score + 1;
            end
        end else if (old == 2 && fe) begin
            m_cnt = (m_cnt + 1) % 16;
        end
        if (rise && old == 0) begin
            m_state = 1; m_score = 0;
        end else if (rise && old == 2) begin
            m_state = 0;
        end
        if (fe) begin
            m_hit = 0; m_at = 0; m_prev = at;
        end else begin
            m_hit = hit; m_at = at;
        end
        m_sp    = st;
        e_fe    = fe;
        e_act   = (m_state == 1);
        e_over  = (m_state == 2);
        e_score = m_score;
    endtask

    // Drives x/y of a new pixel and the RGB belonging to the pixel PIX_LAT earlier.
    task automatic px(input logic [9:0] x, input logic [8:0] y,
                      input logic [23:0] b, input logic [23:0] p);
        logic [9:0] ax; logic [8:0] ay; logic [23:0] ab, ap;
        qx.push_back(x); qy.push_back(y); qb.push_back(b); qp.push_back(p);
        ax = qx.pop_front(); ay = qy.pop_front(); ab = qb.pop_front(); ap = qp.pop_front();
        bus.x = x; bus.y = y; bus.start = start_lvl;
        {bus.bird_r, bus.bird_g, bus.bird_b} = ab;
        {bus.pipe_r, bus.pipe_g, bus.pipe_b} = ap;
        model(ax, ay, ab, ap, start_lvl);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle();         px(10'd0, 9'd0, 24'd0, 24'd0);     endtask
    task automatic drain();        repeat (PIX_LAT) idle();           endtask
    task automatic end_frame();    px(10'd639, 9'd479, 24'd0, 24'd0); endtask
    task automatic pass_frame();   px(10'd120, 9'd50, 24'd0, 24'h00FF00); end_frame(); endtask
    task automatic empty_frame();  px(10'd300, 9'd200, 24'd0, 24'd0);     end_frame(); endtask
    task automatic floor_frame();  px(10'd300, 9'd475, 24'hFF0000, 24'd0); end_frame(); endtask

    task automatic press();
        start_lvl = 1'b1; repeat (2) idle();
        start_lvl = 1'b0; repeat (2) idle();
    endtask

    task automatic go_play();
        if (m_state == 2) press();
        if (m_state == 0) press();
    endtask

    task automatic do_reset(input int cycles);
        resetGame = 1'b1;
        e_vga = '0; e_fe = 0; e_act = 0; e_over = 0; e_coll = 0; e_score = 0;
        repeat (cycles) begin
            @(posedge clk);
            @(negedge clk);
            #1;
        end
        resetGame = 1'b0;
        model_reset();
    endtask

    task automatic random_frame();
        logic [23:0] b, p;
        logic [9:0]  rx;
        int n;
        n = $urandom_range(2, 10);
        for (int i = 0; i < n; i++) begin
            rx = 10'($urandom_range(0, 639));
            if ($urandom_range(0, 5) == 0) rx = 10'd120;
            b = ($urandom_range(0, 5) == 0) ? rnd24() : 24'd0;
            p = ($urandom_range(0, 2) == 0) ? rnd24() : 24'd0;
            if ($urandom_range(0, 9) == 0) start_lvl = ~start_lvl;
            px(rx, 9'($urandom_range(0, 478)), b, p);
        end
        if ($urandom_range(0, 39) == 0) do_reset($urandom_range(1, 3));
        b = ($urandom_range(0, 7) == 0) ? rnd24() : 24'd0;
        p = ($urandom_range(0, 3) == 0) ? rnd24() : 24'd0;
        px(10'd639, 9'd479, b, p);
    endtask

    initial begin
        bus.x = '0; bus.y = '0; bus.start = 1'b0;
        bus.bird_r = '0; bus.bird_g = '0; bus.bird_b = '0;
        bus.pipe_r = '0; bus.pipe_g = '0; bus.pipe_b = '0;
        resetGame = 1'b1;
        e_vga = '0; e_fe = 0; e_act = 0; e_over = 0; e_coll = 0; e_score = 0;
        @(negedge clk);
        #1;
        cmp_en = 1'b1;
        do_reset(2);

        // Empty frame: sky everywhere, a single frame_end PIX_LAT+1 cycles after (639,479).
        fe_cnt = 0;
        for (int i = 0; i < 20; i++) px(10'($urandom_range(0, 638)), 9'($urandom_range(0, 478)), 24'd0, 24'd0);
        end_frame();
        for (int i = 1; i <= PIX_LAT + 1; i++) begin
            idle();
            chk("fe_latency", 32'(bus.frame_end), 32'(i == PIX_LAT));
        end
        chk("fe_count", 32'(fe_cnt), 32'd1);
        chk("sky_lit", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'h70C5CE);
        chk("idle_score", 32'(bus.score), 32'd0);
        chk("idle_active", 32'(bus.game_active), 32'd0);

        // Start held high 10 cycles, then bird over pipe.
        start_lvl = 1'b1;
        repeat (10) idle();
        chk("start_active", 32'(bus.game_active), 32'd1);
        start_lvl = 1'b0;
        coll_cnt = 0;
        px(10'd200, 9'd100, 24'hFFFF00, 24'h00FF00);
        drain();
        chk("bird_pri", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'hFFFF00);
        end_frame();
        drain();
        chk("coll_lit", 32'(bus.collision), 32'd1);
        chk("over_lit", 32'(bus.game_over), 32'd1);
        idle();
        chk("coll_once", 32'(coll_cnt), 32'd1);

        // Pass scoring, then pass + hit in one frame.
        go_play();
        pass_frame(); empty_frame(); drain();
        chk("pass_1", 32'(bus.score), 32'd1);
        empty_frame(); drain();
        chk("pass_hold", 32'(bus.score), 32'd1);
        pass_frame(); floor_frame(); drain();
        chk("passhit_score", 32'(bus.score), 32'd1);
        chk("passhit_over", 32'(bus.game_over), 32'd1);

        // Floor boundary rows.
        go_play();
        px(10'd300, 9'd470, 24'h00FF00, 24'd0); end_frame(); drain();
        chk("floor_470", 32'(bus.game_over), 32'd1);
        go_play();
        px(10'd300, 9'd469, 24'h00FF00, 24'd0); end_frame(); drain();
        chk("floor_469", 32'(bus.game_active), 32'd1);

        // Saturation.
        for (int i = 0; i < SAT; i++) begin
            pass_frame(); empty_frame();
        end
        drain();
        chk("sat_reach", 32'(bus.score), 32'(SAT));
        pass_frame(); empty_frame(); drain();
        chk("sat_hold", 32'(bus.score), 32'(SAT));
        pass_frame(); floor_frame(); drain();
        chk("sat_hit", 32'(bus.score), 32'(SAT));

        // Reset mid-frame during PLAY.
        go_play();
        pass_frame(); empty_frame();
        px(10'd120, 9'd30, 24'd0, 24'h00FF00);
        do_reset(3);
        px(10'd400, 9'd300, 24'd0, 24'd0);
        end_frame(); drain();
        chk("rst_score", 32'(bus.score), 32'd0);
        chk("rst_idle", 32'(bus.game_active), 32'd0);
        press();
        chk("rst_play", 32'(bus.game_active), 32'd1);
        chk("rst_play_score", 32'(bus.score), 32'd0);

        // Rendering during OVER, frame by frame.
        floor_frame();
        for (int f = 1; f <= 16; f++) begin
            px(10'd10, 9'd10, 24'd0, 24'd0);
            drain();
            chk("over_render", 32'({bus.vga_r, bus.vga_g, bus.vga_b}),
                (FLASH && f > 8) ? 32'h8F3A31 : 32'h70C5CE);
            end_frame();
        end

        for (int i = 0; i < 300; i++) random_frame();
        repeat (PIX_LAT + 2) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
